// File: rtl/pipe_mem.sv
// MEM pipeline stage: one word-aligned req/ack data-memory access per load/store, registered WB bundle.
// Optional request watchdog enabled by defining PIPE_MEM_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module pipe_mem #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        in_valid,
  input  logic        in_dmem_ena,
  input  logic        in_dmem_wena,
  input  logic [1:0]  in_dmem_type,
  input  logic        in_dmem_sign,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_rt_data,
  input  logic [4:0]  in_rd_waddr,
  input  logic        in_rd_sel,
  input  logic        in_rd_wena,
  output logic        out_stall,
  output logic        out_mem_req,
  output logic        out_mem_we,
  output logic [31:0] out_mem_addr,
  output logic [3:0]  out_mem_wmask,
  output logic [31:0] out_mem_wdata,
  input  logic        in_mem_ack,
  input  logic [31:0] in_mem_rdata,
  output logic        out_valid,
  output logic [4:0]  out_rd_waddr,
  output logic        out_rd_sel,
  output logic        out_rd_wena,
  output logic [31:0] out_alu_result,
  output logic [31:0] out_mem_data,
  output logic        out_misalign,
  output logic        out_bus_err
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  localparam logic [1:0] T_HALF = 2'b01;
  localparam logic [1:0] T_BYTE = 2'b10;

  state_t      r_state;
  state_t      w_next;

  logic        r_valid;
  logic        r_misalign;
  logic        r_bus_err;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_wmask;
  logic [31:0] r_mem_wdata;
  logic [4:0]  r_rd_waddr;
  logic        r_rd_sel;
  logic        r_rd_wena;
  logic [31:0] r_alu_result;
  logic [31:0] r_mem_data;

  // Bundle fields parked while a request is outstanding.
  logic [4:0]  r_p_rd_waddr;
  logic        r_p_rd_sel;
  logic        r_p_rd_wena;
  logic [31:0] r_p_alu;
  logic [1:0]  r_p_type;
  logic        r_p_sign;

  logic        w_accept;
  logic        w_misalign;
  logic        w_issue;
  logic [3:0]  w_wmask;
  logic [31:0] w_wdata;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic [31:0] w_load_data;
  logic        w_timeout;

  always_comb begin
    w_accept   = (r_state == S_IDLE) && in_valid;
    w_misalign = 1'b0;
    case (in_dmem_type)
      T_HALF:  w_misalign = in_alu_result[0];
      T_BYTE:  w_misalign = 1'b0;
      default: w_misalign = (in_alu_result[1:0] != 2'b00);
    endcase
    w_issue = w_accept && in_dmem_ena && !w_misalign;
  end

  always_comb begin
    w_wmask = 4'b1111;
    w_wdata = in_rt_data;
    case (in_dmem_type)
      T_HALF: begin
        w_wmask = in_alu_result[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{in_rt_data[15:0]}};
      end
      T_BYTE: begin
        w_wmask = 4'b0001 << in_alu_result[1:0];
        w_wdata = {4{in_rt_data[7:0]}};
      end
      default: begin
        w_wmask = 4'b1111;
        w_wdata = in_rt_data;
      end
    endcase
    if (!in_dmem_wena) begin
      w_wmask = '0;
    end
  end

  always_comb begin
    w_half      = r_p_alu[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];
    w_byte      = in_mem_rdata[7:0];
    case (r_p_alu[1:0])
      2'b01:   w_byte = in_mem_rdata[15:8];
      2'b10:   w_byte = in_mem_rdata[23:16];
      2'b11:   w_byte = in_mem_rdata[31:24];
      default: w_byte = in_mem_rdata[7:0];
    endcase
    w_load_data = in_mem_rdata;
    case (r_p_type)
      T_HALF:  w_load_data = {{16{r_p_sign & w_half[15]}}, w_half};
      T_BYTE:  w_load_data = {{24{r_p_sign & w_byte[7]}}, w_byte};
      default: w_load_data = in_mem_rdata;
    endcase
  end

`ifdef PIPE_MEM_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_to_cnt;

  // Counter restarts every IDLE cycle so it is zero on the first WAIT cycle.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_to_cnt <= '0;
    end else if (r_state == S_WAIT && !in_mem_ack) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign w_timeout = (r_state == S_WAIT) && !in_mem_ack && (r_to_cnt == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_next = S_WAIT;
      S_WAIT:  if (in_mem_ack || w_timeout) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_valid      <= 1'b0;
      r_misalign   <= 1'b0;
      r_bus_err    <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wmask  <= '0;
      r_mem_wdata  <= '0;
      r_rd_waddr   <= '0;
      r_rd_sel     <= 1'b0;
      r_rd_wena    <= 1'b0;
      r_alu_result <= '0;
      r_mem_data   <= '0;
      r_p_rd_waddr <= '0;
      r_p_rd_sel   <= 1'b0;
      r_p_rd_wena  <= 1'b0;
      r_p_alu      <= '0;
      r_p_type     <= '0;
      r_p_sign     <= 1'b0;
    end else begin
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_accept) begin
          if (w_issue) begin
            r_mem_req    <= 1'b1;
            r_mem_we     <= in_dmem_wena;
            r_mem_addr   <= {in_alu_result[31:2], 2'b00};
            r_mem_wmask  <= w_wmask;
            r_mem_wdata  <= w_wdata;
            r_p_rd_waddr <= in_rd_waddr;
            r_p_rd_sel   <= in_rd_sel;
            r_p_rd_wena  <= in_rd_wena;
            r_p_alu      <= in_alu_result;
            r_p_type     <= in_dmem_type;
            r_p_sign     <= in_dmem_sign;
          end else begin
            r_valid      <= 1'b1;
            r_misalign   <= in_dmem_ena;
            r_rd_waddr   <= in_rd_waddr;
            r_rd_sel     <= in_rd_sel;
            r_rd_wena    <= in_rd_wena && !in_dmem_ena;
            r_alu_result <= in_alu_result;
            r_mem_data   <= '0;
          end
        end
      end else if (in_mem_ack || w_timeout) begin
        // Ack has priority; a timeout completes with the write-back suppressed.
        r_valid      <= 1'b1;
        r_bus_err    <= !in_mem_ack;
        r_mem_req    <= 1'b0;
        r_mem_we     <= 1'b0;
        r_mem_wmask  <= '0;
        r_rd_waddr   <= r_p_rd_waddr;
        r_rd_sel     <= r_p_rd_sel;
        r_rd_wena    <= r_p_rd_wena && in_mem_ack;
        r_alu_result <= r_p_alu;
        r_mem_data   <= (in_mem_ack && !r_mem_we) ? w_load_data : '0;
      end
    end
  end

  assign out_stall      = (r_state == S_WAIT);
  assign out_mem_req    = r_mem_req;
  assign out_mem_we     = r_mem_we;
  assign out_mem_addr   = r_mem_addr;
  assign out_mem_wmask  = r_mem_wmask;
  assign out_mem_wdata  = r_mem_wdata;
  assign out_valid      = r_valid;
  assign out_rd_waddr   = r_rd_waddr;
  assign out_rd_sel     = r_rd_sel;
  assign out_rd_wena    = r_rd_wena;
  assign out_alu_result = r_alu_result;
  assign out_mem_data   = r_mem_data;
  assign out_misalign   = r_misalign;
  assign out_bus_err    = r_bus_err;

endmodule

// File: tb/tb_pipe_mem.sv
// Scoreboard bench for pipe_mem: stimulus pushes expected WB bundles, a negedge monitor pops on out_valid.
module tb_pipe_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_dmem_ena, in_dmem_wena, in_dmem_sign;
  logic [1:0]  in_dmem_type;
  logic [31:0] in_alu_result, in_rt_data, in_mem_rdata;
  logic [4:0]  in_rd_waddr;
  logic        in_rd_sel, in_rd_wena, in_mem_ack;
  logic        out_stall, out_mem_req, out_mem_we, out_valid;
  logic [31:0] out_mem_addr, out_mem_wdata, out_alu_result, out_mem_data;
  logic [3:0]  out_mem_wmask;
  logic [4:0]  out_rd_waddr;
  logic        out_rd_sel, out_rd_wena, out_misalign, out_bus_err;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        sel;
    logic        wena;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t q[$];

  pipe_mem #(.TIMEOUT_CYCLES(4)) dut (
    .in_clk(clk), .in_rst(rst), .in_valid(in_valid),
    .in_dmem_ena(in_dmem_ena), .in_dmem_wena(in_dmem_wena),
    .in_dmem_type(in_dmem_type), .in_dmem_sign(in_dmem_sign),
    .in_alu_result(in_alu_result), .in_rt_data(in_rt_data),
    .in_rd_waddr(in_rd_waddr), .in_rd_sel(in_rd_sel), .in_rd_wena(in_rd_wena),
    .out_stall(out_stall), .out_mem_req(out_mem_req), .out_mem_we(out_mem_we),
    .out_mem_addr(out_mem_addr), .out_mem_wmask(out_mem_wmask),
    .out_mem_wdata(out_mem_wdata), .in_mem_ack(in_mem_ack),
    .in_mem_rdata(in_mem_rdata), .out_valid(out_valid),
    .out_rd_waddr(out_rd_waddr), .out_rd_sel(out_rd_sel),
    .out_rd_wena(out_rd_wena), .out_alu_result(out_alu_result),
    .out_mem_data(out_mem_data), .out_misalign(out_misalign),
    .out_bus_err(out_bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every completion must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_valid: got out_valid=1 alu=0x%08h expected no completion", out_alu_result);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wb_alu", out_alu_result, e.alu);
        chk("wb_data", out_mem_data, e.data);
        chk("wb_rd", {27'b0, out_rd_waddr}, {27'b0, e.rd});
        chk("wb_flags", {28'b0, out_rd_sel, out_rd_wena, out_misalign, out_bus_err},
            {28'b0, e.sel, e.wena, e.mis, e.berr});
      end
    end else if (!rst && (out_misalign || out_bus_err)) begin
      chk("flag_without_valid", {30'b0, out_misalign, out_bus_err}, 32'd0);
    end
  end

  task automatic drive(input logic ena, input logic we, input logic [1:0] typ, input logic sign,
                       input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] rd,
                       input logic sel, input logic wena);
    in_valid      = 1'b1;
    in_dmem_ena   = ena;
    in_dmem_wena  = we;
    in_dmem_type  = typ;
    in_dmem_sign  = sign;
    in_alu_result = alu;
    in_rt_data    = rt;
    in_rd_waddr   = rd;
    in_rd_sel     = sel;
    in_rd_wena    = wena;
  endtask

  task automatic nonmem(input logic [31:0] alu, input logic [4:0] rd, input logic sel,
                        input logic wena, input bit drop);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 1'b0, alu, 32'h5555_AAAA, rd, sel, wena);
    q.push_back('{alu: alu, data: 32'h0, rd: rd, sel: sel, wena: wena, mis: 1'b0, berr: 1'b0});
    @(posedge clk); #1;
    chk("nonmem_latency", {31'b0, out_valid}, 32'd1);
    chk("nonmem_no_req", {31'b0, out_mem_req}, 32'd0);
    if (drop) in_valid = 1'b0;
  endtask

  task automatic misaligned(input logic we, input logic [1:0] typ, input logic [31:0] alu,
                            input logic [4:0] rd);
    @(negedge clk);
    drive(1'b1, we, typ, 1'b0, alu, 32'h1111_2222, rd, 1'b1, 1'b1);
    q.push_back('{alu: alu, data: 32'h0, rd: rd, sel: 1'b1, wena: 1'b0, mis: 1'b1, berr: 1'b0});
    @(posedge clk); #1;
    chk("misalign_no_req", {31'b0, out_mem_req}, 32'd0);
    chk("misalign_no_stall", {31'b0, out_stall}, 32'd0);
    chk("misalign_valid", {31'b0, out_valid}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic mem_op(input logic we, input logic [1:0] typ, input logic sign,
                        input logic [31:0] addr, input logic [31:0] rt, input logic [4:0] rd,
                        input logic wena, input int delay, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic [3:0] exp_mask,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_data);
    int stalls;
    stalls = 0;
    @(negedge clk);
    drive(1'b1, we, typ, sign, addr, rt, rd, 1'b0, wena);
    q.push_back('{alu: addr, data: exp_data, rd: rd, sel: 1'b0, wena: wena, mis: 1'b0, berr: 1'b0});
    @(posedge clk); #1;
    chk("req_rise", {31'b0, out_mem_req}, 32'd1);
    chk("req_we", {31'b0, out_mem_we}, {31'b0, we});
    chk("req_addr", out_mem_addr, exp_addr);
    chk("req_wmask", {28'b0, out_mem_wmask}, {28'b0, exp_mask});
    chk("req_wdata", out_mem_wdata, exp_wdata);
    for (int k = 0; k < delay; k++) begin
      @(negedge clk);
      if (out_stall) stalls++;
      chk("req_hold", {out_mem_addr[31:1], out_mem_req}, {exp_addr[31:1], 1'b1});
    end
    @(negedge clk);
    if (out_stall) stalls++;
    in_mem_ack   = 1'b1;
    in_mem_rdata = rdata;
    @(posedge clk); #1;
    in_mem_ack   = 1'b0;
    in_mem_rdata = 32'hDEAD_0000;
    in_valid     = 1'b0;
    chk("ack_valid", {31'b0, out_valid}, 32'd1);
    chk("ack_req_drop", {30'b0, out_mem_req, out_stall}, 32'd0);
    chk("stall_cycles", stalls, delay + 1);
  endtask

  initial begin
    rst = 1'b1;
    in_mem_ack = 1'b1;
    in_mem_rdata = 32'hFFFF_FFFF;
    drive(1'b1, 1'b1, 2'b00, 1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 5'd31, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {26'b0, out_valid, out_stall, out_mem_req, out_mem_we, out_misalign, out_bus_err}, 32'd0);
    chk("rst_addr", out_mem_addr, 32'd0);
    chk("rst_mask_rd", {20'b0, out_mem_wmask, out_rd_waddr, out_rd_sel, out_rd_wena, 1'b0}, 32'd0);
    chk("rst_wdata", out_mem_wdata, 32'd0);
    chk("rst_alu", out_alu_result, 32'd0);
    chk("rst_data", out_mem_data, 32'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    in_mem_ack = 1'b0;

    nonmem(32'h0000_1234, 5'd3, 1'b1, 1'b1, 1'b1);

    // store byte at 0x103, two wait cycles before ack
    mem_op(1'b1, 2'b10, 1'b0, 32'h0000_0103, 32'h0000_00AB, 5'd0, 1'b0, 2, 32'h0,
           32'h0000_0100, 4'b1000, 32'hABAB_ABAB, 32'h0);
    // load half sign/zero at 0x202, ack same cycle as req
    mem_op(1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0, 5'd4, 1'b1, 0, 32'h8001_FFFF,
           32'h0000_0200, 4'b0000, 32'h0, 32'hFFFF_8001);
    mem_op(1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0, 5'd5, 1'b1, 1, 32'h8001_FFFF,
           32'h0000_0200, 4'b0000, 32'h0, 32'h0000_8001);
    // byte loads lanes 1 and 3
    mem_op(1'b0, 2'b10, 1'b1, 32'h0000_0301, 32'h0, 5'd6, 1'b1, 0, 32'h1234_F6AA,
           32'h0000_0300, 4'b0000, 32'h0, 32'hFFFF_FFF6);
    mem_op(1'b0, 2'b10, 1'b0, 32'h0000_0303, 32'h0, 5'd7, 1'b1, 3, 32'h80AA_BBCC,
           32'h0000_0300, 4'b0000, 32'h0, 32'h0000_0080);
    // half store upper lane, word store, reserved type as word load
    mem_op(1'b1, 2'b01, 1'b0, 32'h0000_0402, 32'h0000_BEEF, 5'd0, 1'b0, 0, 32'h0,
           32'h0000_0400, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    mem_op(1'b1, 2'b00, 1'b0, 32'h0000_0500, 32'hDEAD_BEEF, 5'd0, 1'b0, 1, 32'h0,
           32'h0000_0500, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    mem_op(1'b0, 2'b11, 1'b1, 32'h0000_0600, 32'h0, 5'd9, 1'b1, 0, 32'hCAFE_F00D,
           32'h0000_0600, 4'b0000, 32'hCAFE_F00D & 32'h0, 32'hCAFE_F00D);

    misaligned(1'b0, 2'b00, 32'h0000_0006, 5'd10);
    misaligned(1'b1, 2'b01, 32'h0000_0011, 5'd11);
    misaligned(1'b0, 2'b11, 32'h0000_0602, 5'd12);

    // back-to-back non-memory ops
    nonmem(32'h0000_0A01, 5'd1, 1'b0, 1'b1, 1'b0);
    nonmem(32'h0000_0A02, 5'd2, 1'b1, 1'b0, 1'b0);
    nonmem(32'h0000_0A03, 5'd3, 1'b0, 1'b1, 1'b1);

    // ack while idle is ignored
    @(negedge clk);
    in_mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ack_no_stall", {31'b0, out_stall}, 32'd0);
    in_mem_ack = 1'b0;

    // reset during WAIT discards the request
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0700, 32'h0, 5'd13, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("pre_rst_req", {31'b0, out_mem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_req_drop", {30'b0, out_mem_req, out_stall}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    mem_op(1'b0, 2'b00, 1'b0, 32'h0000_0704, 32'h0, 5'd14, 1'b1, 1, 32'h0BAD_CAFE,
           32'h0000_0704, 4'b0000, 32'h0, 32'h0BAD_CAFE);

`ifdef PIPE_MEM_TIMEOUT_EN
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0800, 32'h0, 5'd15, 1'b0, 1'b1);
    q.push_back('{alu: 32'h0000_0800, data: 32'h0, rd: 5'd15, sel: 1'b0, wena: 1'b0, mis: 1'b0, berr: 1'b1});
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("to_waiting", {30'b0, out_valid, out_mem_req}, 32'd1);
    end
    @(posedge clk); #1;
    chk("to_fire", {29'b0, out_valid, out_bus_err, out_mem_req}, 32'd6);
    chk("to_idle", {31'b0, out_stall}, 32'd0);
    in_valid = 1'b0;
    nonmem(32'h0000_0900, 5'd16, 1'b0, 1'b1, 1'b1);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
